// File: rtl/i2s_pkg.sv
// i2s_pkg: shared state encoding and default framing constants for the I2S receiver.
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_BITS = 24;
  localparam int unsigned DEF_SLOT_BITS = 32;

endpackage

// File: rtl/i2s_sync.sv
// i2s_sync: 2-FF synchronizer for one asynchronous input plus a registered
// rising-edge pulse of the synchronized level.
module i2s_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise
);

  logic ff1;
  logic ff2;
  logic prev;

  assign dout = ff2;

  // Two-stage metastability filter, then a one-clk pulse on each 0->1 transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      ff1  <= 1'b0;
      ff2  <= 1'b0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      ff1  <= din;
      ff2  <= ff1;
      prev <= ff2;
      rise <= ff2 & ~prev;
    end
  end

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S slave receiver. Captures DATA_BITS MSB-first per slot, emits the top
// WIDTH bits as a one-clk valid strobe, and flags framing errors.
// Build option: define I2S_RX_STEREO_EN to emit both channels; otherwise only left
// (ws = 0) slots produce samples and channel stays 0.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DATA_BITS = DEF_DATA_BITS,
  parameter int unsigned SLOT_BITS = DEF_SLOT_BITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i2s_sck,
  input  logic             i2s_ws,
  input  logic             i2s_sd,
  output logic [WIDTH-1:0] sample_out,
  output logic             valid,
  output logic             channel,
  output logic             frame_err
);

  localparam int unsigned CNT_W  = $clog2(DATA_BITS + 1);
  localparam int unsigned SLOT_W = $clog2(2 * SLOT_BITS + 1);
  localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(DATA_BITS - 1);
  localparam logic [SLOT_W-1:0] SLOT_LIMIT = SLOT_W'(2 * SLOT_BITS - 1);

`ifdef I2S_RX_STEREO_EN
  localparam logic STEREO = 1'b1;
`else
  localparam logic STEREO = 1'b0;
`endif

  logic                 sck_rise;
  logic                 sck_level_unused;
  logic                 ws_s;
  logic                 ws_rise_unused;
  logic                 sd_s;
  logic                 sd_rise_unused;

  state_t               state;
  logic                 ws_prev;
  logic                 slot_ch;
  logic                 done_ch;
  logic                 word_done;
  logic [CNT_W-1:0]     bit_cnt;
  logic [SLOT_W-1:0]    slot_cnt;
  logic [DATA_BITS-1:0] shreg;

  logic                 ws_chg;
  logic                 timeout;
  state_t               start_state;
  logic [DATA_BITS-1:0] shreg_next;

  i2s_sync u_sync_sck (
    .clk   (clk),
    .reset (reset),
    .din   (i2s_sck),
    .dout  (sck_level_unused),
    .rise  (sck_rise)
  );

  i2s_sync u_sync_ws (
    .clk   (clk),
    .reset (reset),
    .din   (i2s_ws),
    .dout  (ws_s),
    .rise  (ws_rise_unused)
  );

  i2s_sync u_sync_sd (
    .clk   (clk),
    .reset (reset),
    .din   (i2s_sd),
    .dout  (sd_s),
    .rise  (sd_rise_unused)
  );

  // Per-bit-edge decode: slot boundary, runaway slot, and where a new slot goes.
  assign ws_chg      = ws_s ^ ws_prev;
  assign timeout     = (state != IDLE) && (slot_cnt == SLOT_LIMIT);
  assign start_state = (!STEREO && ws_s) ? WAIT : SHIFT;
  assign shreg_next  = {shreg[DATA_BITS-2:0], sd_s};

  // Slot FSM; a finished word is published one clk after its last bit is shifted in.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ws_prev    <= 1'b0;
      slot_ch    <= 1'b0;
      done_ch    <= 1'b0;
      word_done  <= 1'b0;
      bit_cnt    <= '0;
      slot_cnt   <= '0;
      shreg      <= '0;
      sample_out <= '0;
      channel    <= 1'b0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid     <= word_done;
      frame_err <= 1'b0;
      word_done <= 1'b0;

      if (word_done) begin
        sample_out <= shreg[DATA_BITS-1 -: WIDTH];
        channel    <= done_ch & STEREO;
      end

      if (sck_rise) begin
        ws_prev  <= ws_s;
        slot_cnt <= (ws_chg || state == IDLE) ? '0 : slot_cnt + SLOT_W'(1);

        if (ws_chg) begin
          // The ws-change edge still carries the previous slot's final bit.
          if (state == SHIFT) begin
            if (bit_cnt == LAST_BIT) begin
              shreg     <= shreg_next;
              word_done <= 1'b1;
              done_ch   <= slot_ch;
            end else begin
              frame_err <= 1'b1;
            end
          end
          state   <= start_state;
          bit_cnt <= '0;
          slot_ch <= ws_s;
        end else if (timeout) begin
          frame_err <= 1'b1;
          state     <= IDLE;
          bit_cnt   <= '0;
          slot_cnt  <= '0;
        end else if (state == SHIFT) begin
          shreg   <= shreg_next;
          bit_cnt <= bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            word_done <= 1'b1;
            done_ch   <= slot_ch;
            state     <= WAIT;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: directed self-checking bench for i2s_rx (sck = clk/16, 32-bit slots,
// 24 data bits). Expectations follow the I2S_RX_STEREO_EN build setting.
module tb_i2s_rx;

`ifdef I2S_RX_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        i2s_sck;
  logic        i2s_ws;
  logic        i2s_sd;
  logic [15:0] sample_out;
  logic        valid;
  logic        channel;
  logic        frame_err;

  int n_cmp = 0;
  int n_bad = 0;

  int   cyc = 0;
  int   last_rise = 0;
  int   latency = -1;
  logic sck_seen = 1'b0;
  int   n_valid = 0;
  int   n_err = 0;
  int   n_overlap = 0;
  logic [15:0] cap_s[$];
  logic        cap_c[$];

  always #5 clk = ~clk;

  i2s_rx #(.WIDTH(16), .DATA_BITS(24), .SLOT_BITS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .i2s_sck    (i2s_sck),
    .i2s_ws     (i2s_ws),
    .i2s_sd     (i2s_sd),
    .sample_out (sample_out),
    .valid      (valid),
    .channel    (channel),
    .frame_err  (frame_err)
  );

  // Cycle counter and the clk edge that first sees raw sck high.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (i2s_sck === 1'b1 && sck_seen === 1'b0) last_rise = cyc;
    sck_seen = i2s_sck;
  end

  // Output monitor, sampled on the falling clk edge.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      n_valid = n_valid + 1;
      cap_s.push_back(sample_out);
      cap_c.push_back(channel);
      latency = cyc - last_rise;
    end
    if (frame_err === 1'b1) n_err = n_err + 1;
    if (valid === 1'b1 && frame_err === 1'b1) n_overlap = n_overlap + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_mon();
    n_valid = 0;
    n_err = 0;
    n_overlap = 0;
    latency = -1;
    cap_s.delete();
    cap_c.delete();
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    i2s_sck = 1'b0;
    i2s_ws  = 1'b0;
    i2s_sd  = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    clear_mon();
  endtask

  task automatic align(input int off);
    @(posedge clk);
    #(5 + off);
  endtask

  task automatic send_bit(input logic w, input logic d);
    i2s_sck = 1'b0;
    i2s_ws  = w;
    i2s_sd  = d;
    #80;
    i2s_sck = 1'b1;
    #80;
  endtask

  task automatic send_partial(input logic w, input logic [23:0] data, input int n);
    send_bit(w, 1'b0);
    for (int i = 0; i < n; i++) send_bit(w, data[23 - i]);
  endtask

  task automatic send_slot(input logic w, input logic [23:0] data);
    send_partial(w, data, 24);
    for (int i = 0; i < 7; i++) send_bit(w, 1'b0);
  endtask

  // A zero right slot gives the receiver its first ws change after reset.
  task automatic prelude();
    send_slot(1'b1, 24'h000000);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (sample_out !== 16'h0000) begin n_bad++; $display("FAIL reset_sample: got %h want 0000", sample_out); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_cmp++; if (channel !== 1'b0) begin n_bad++; $display("FAIL reset_channel: got %b want 0", channel); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
  endtask

  task automatic test_frame();
    logic [15:0] es[$];
    logic        ec[$];
    es.push_back(16'h7FFF); ec.push_back(1'b0);
    if (STEREO) begin es.push_back(16'h8001); ec.push_back(1'b1); end
    do_reset();
    align(2);
    prelude();
    clear_mon();
    send_slot(1'b0, 24'h7FFF00);
    send_slot(1'b1, 24'h800100);
    n_cmp++; if (n_valid !== es.size()) begin n_bad++; $display("FAIL frame_count: got %0d want %0d", n_valid, es.size()); end
    for (int i = 0; i < es.size() && i < cap_s.size(); i++) begin
      n_cmp++; if (cap_s[i] !== es[i]) begin n_bad++; $display("FAIL frame_sample[%0d]: got %h want %h", i, cap_s[i], es[i]); end
      n_cmp++; if (cap_c[i] !== ec[i]) begin n_bad++; $display("FAIL frame_channel[%0d]: got %b want %b", i, cap_c[i], ec[i]); end
    end
    n_cmp++; if (sample_out !== es[es.size()-1]) begin n_bad++; $display("FAIL frame_hold: got %h want %h", sample_out, es[es.size()-1]); end
    n_cmp++; if (n_err !== 0) begin n_bad++; $display("FAIL frame_err_count: got %0d want 0", n_err); end
    n_cmp++; if (n_overlap !== 0) begin n_bad++; $display("FAIL frame_overlap: got %0d want 0", n_overlap); end
  endtask

  task automatic test_latency();
    int offs[3] = '{1, 4, 8};
    for (int k = 0; k < 3; k++) begin
      do_reset();
      align(offs[k]);
      prelude();
      clear_mon();
      send_slot(1'b0, 24'h5A5A5A);
      n_cmp++; if (n_valid !== 1) begin n_bad++; $display("FAIL latency_count off=%0d: got %0d want 1", offs[k], n_valid); end
      n_cmp++; if (latency !== 4) begin n_bad++; $display("FAIL latency off=%0d: got %0d want 4", offs[k], latency); end
      if (cap_s.size() > 0) begin
        n_cmp++; if (cap_s[0] !== 16'h5A5A) begin n_bad++; $display("FAIL latency_sample off=%0d: got %h want 5a5a", offs[k], cap_s[0]); end
      end
    end
  endtask

  task automatic test_frame_err();
    logic [15:0] es[$];
    logic        ec[$];
    if (STEREO) begin es.push_back(16'h1234); ec.push_back(1'b1); end
    es.push_back(16'h6543); ec.push_back(1'b0);
    do_reset();
    align(3);
    prelude();
    clear_mon();
    send_partial(1'b0, 24'hABCDEF, 10);
    send_slot(1'b1, 24'h123456);
    send_slot(1'b0, 24'h654321);
    n_cmp++; if (n_err !== 1) begin n_bad++; $display("FAIL ferr_count: got %0d want 1", n_err); end
    n_cmp++; if (n_valid !== es.size()) begin n_bad++; $display("FAIL ferr_valid_count: got %0d want %0d", n_valid, es.size()); end
    for (int i = 0; i < es.size() && i < cap_s.size(); i++) begin
      n_cmp++; if (cap_s[i] !== es[i]) begin n_bad++; $display("FAIL ferr_sample[%0d]: got %h want %h", i, cap_s[i], es[i]); end
      n_cmp++; if (cap_c[i] !== ec[i]) begin n_bad++; $display("FAIL ferr_channel[%0d]: got %b want %b", i, cap_c[i], ec[i]); end
    end
    n_cmp++; if (n_overlap !== 0) begin n_bad++; $display("FAIL ferr_overlap: got %0d want 0", n_overlap); end
  endtask

  task automatic test_timeout();
    logic [15:0] es[$];
    logic        ec[$];
    es.push_back(16'h1111); ec.push_back(1'b0);
    if (STEREO) begin es.push_back(16'h2222); ec.push_back(1'b1); end
    es.push_back(16'h3333); ec.push_back(1'b0);
    do_reset();
    align(6);
    prelude();
    clear_mon();
    send_slot(1'b0, 24'h111111);
    for (int i = 0; i < 40; i++) send_bit(1'b0, 1'b1);
    send_slot(1'b1, 24'h222222);
    send_slot(1'b0, 24'h333333);
    n_cmp++; if (n_err !== 1) begin n_bad++; $display("FAIL timeout_err_count: got %0d want 1", n_err); end
    n_cmp++; if (n_valid !== es.size()) begin n_bad++; $display("FAIL timeout_valid_count: got %0d want %0d", n_valid, es.size()); end
    for (int i = 0; i < es.size() && i < cap_s.size(); i++) begin
      n_cmp++; if (cap_s[i] !== es[i]) begin n_bad++; $display("FAIL timeout_sample[%0d]: got %h want %h", i, cap_s[i], es[i]); end
      n_cmp++; if (cap_c[i] !== ec[i]) begin n_bad++; $display("FAIL timeout_channel[%0d]: got %b want %b", i, cap_c[i], ec[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int pre_n;
    pre_n = STEREO ? 2 : 1;
    do_reset();
    align(7);
    prelude();
    clear_mon();
    send_slot(1'b0, 24'h4321AB);
    send_slot(1'b1, 24'h00FF00);
    send_partial(1'b0, 24'hFFFFFF, 12);
    reset   = 1'b1;
    i2s_sck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (sample_out !== 16'h0000) begin n_bad++; $display("FAIL rstmid_sample: got %h want 0000", sample_out); end
    n_cmp++; if (channel !== 1'b0) begin n_bad++; $display("FAIL rstmid_channel: got %b want 0", channel); end
    n_cmp++; if (valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid: got %b want 0", valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_frame_err: got %b want 0", frame_err); end
    n_cmp++; if (n_valid !== pre_n) begin n_bad++; $display("FAIL rstmid_valid_count: got %0d want %0d", n_valid, pre_n); end
    n_cmp++; if (n_err !== 0) begin n_bad++; $display("FAIL rstmid_err_count: got %0d want 0", n_err); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    i2s_ws = 1'b0;
    i2s_sd = 1'b0;
    prelude();
    clear_mon();
    send_slot(1'b0, 24'h0F0F0F);
    n_cmp++; if (n_valid !== 1) begin n_bad++; $display("FAIL rstmid_after_count: got %0d want 1", n_valid); end
    if (cap_s.size() > 0) begin
      n_cmp++; if (cap_s[0] !== 16'h0F0F) begin n_bad++; $display("FAIL rstmid_after_sample: got %h want 0f0f", cap_s[0]); end
      n_cmp++; if (cap_c[0] !== 1'b0) begin n_bad++; $display("FAIL rstmid_after_channel: got %b want 0", cap_c[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_latency();
    test_frame_err();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
